// File: rtl/set_drv_pkg.sv
// Shared types and constants for the SET pattern driver.
// Holds the driver state encoding, the SET mode codes and the error
// saturation value used by set_pattern_driver and its watchdog.
package set_drv_pkg;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        LOAD,
        WAIT_RDY,
        ISSUE,
        WAIT_VLD,
        CHECK,
        DONE
    } drv_state_e;

    localparam logic [1:0] MODE_CAND  = 2'b00;
    localparam logic [1:0] MODE_UNION = 2'b01;
    localparam logic [1:0] MODE_DIFF  = 2'b10;
    localparam logic [1:0] MODE_ISECT = 2'b11;

    localparam logic [7:0] ERR_SAT = 8'd255;

endpackage

// File: rtl/set_drv_wdog.sv
// Per-job watchdog for the SET pattern driver.
// A 16-bit counter that clears on request, advances while enabled and
// reports expiry once it has counted LIMIT cycles. It stops at LIMIT so a
// long stall can never wrap around and hide the timeout.
module set_drv_wdog #(
    parameter int LIMIT = 4096
) (
    input  logic clk,
    input  logic rst,
    input  logic clear_i,
    input  logic countEn_i,
    output logic expire_o
);

    localparam logic [15:0] LIMIT_W = 16'(LIMIT);

    logic [15:0] count_q;
    logic [15:0] count_d;

    // Next count: clear wins, otherwise advance until the limit is reached.
    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (countEn_i && (count_q != LIMIT_W)) begin
            count_d = count_q + 16'd1;
        end
    end

    // Counter register, cleared asynchronously with the rest of the driver.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expire_o = (count_q == LIMIT_W);

endmodule

// File: rtl/set_pattern_driver.sv
// On-chip initiator and checker for the SET circle-set candidate engine.
// Walks NUM_PAT entries of a synchronous pattern ROM, issues each job to SET
// through the en/busy/valid handshake, compares the returned candidate with
// the expected one and reports done/pass/err_cnt/fail_idx.
// Optional build macro SET_DRV_WDOG_EN adds a per-job watchdog that aborts
// the run (err_cnt forced to 255) after WDOG_CYC cycles of waiting.
module set_pattern_driver
    import set_drv_pkg::*;
#(
    parameter int NUM_PAT = 64,
    parameter int ADDR_W  = 6,
    parameter int MAX_ERR = 10
`ifdef SET_DRV_WDOG_EN
    ,
    parameter int WDOG_CYC = 4096
`endif
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [1:0]        mode_sel,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [23:0]       rom_central,
    input  logic [11:0]       rom_radius,
    input  logic [7:0]        rom_expected,
    output logic              set_en,
    output logic [23:0]       set_central,
    output logic [11:0]       set_radius,
    output logic [1:0]        set_mode,
    input  logic              set_busy,
    input  logic              set_valid,
    input  logic [7:0]        set_candidate,
    output logic              running,
    output logic              done,
    output logic              pass,
    output logic [7:0]        err_cnt,
    output logic [ADDR_W-1:0] fail_idx
);

    localparam logic [ADDR_W-1:0] LAST_IDX  = ADDR_W'(NUM_PAT - 1);
    localparam logic [ADDR_W-1:0] IDX_ONE   = ADDR_W'(1);
    localparam logic [7:0]        MAX_ERR_B = 8'(MAX_ERR);

    drv_state_e        state_q, state_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic [23:0]       setCentral_q, setCentral_d;
    logic [11:0]       setRadius_q, setRadius_d;
    logic [1:0]        setMode_q, setMode_d;
    logic [7:0]        exp_q, exp_d;
    logic [7:0]        cand_q, cand_d;
    logic [7:0]        errCnt_q, errCnt_d;
    logic [ADDR_W-1:0] failIdx_q, failIdx_d;
    logic              pass_q, pass_d;
    logic [7:0]        errNext;

`ifdef SET_DRV_WDOG_EN
    logic wdogCount;
    logic wdogExpire;

    assign wdogCount = (state_q == WAIT_RDY) || (state_q == WAIT_VLD);

    set_drv_wdog #(
        .LIMIT(WDOG_CYC)
    ) uWdog (
        .clk      (clk),
        .rst      (rst),
        .clear_i  (!wdogCount),
        .countEn_i(wdogCount),
        .expire_o (wdogExpire)
    );
`endif

    // Next-state and datapath updates for the fetch/issue/check job loop.
    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        setCentral_d = setCentral_q;
        setRadius_d  = setRadius_q;
        setMode_d    = setMode_q;
        exp_d        = exp_q;
        cand_d       = cand_q;
        errCnt_d     = errCnt_q;
        failIdx_d    = failIdx_q;
        pass_d       = pass_q;
        errNext      = errCnt_q;

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    idx_d     = '0;
                    errCnt_d  = '0;
                    failIdx_d = '0;
                    pass_d    = 1'b0;
                    setMode_d = mode_sel;
                    state_d   = FETCH;
                end
            end
            FETCH: begin
                state_d = LOAD;
            end
            LOAD: begin
                setCentral_d = rom_central;
                setRadius_d  = rom_radius;
                exp_d        = rom_expected;
                state_d      = WAIT_RDY;
            end
            WAIT_RDY: begin
                if (!set_busy) begin
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                state_d = WAIT_VLD;
            end
            WAIT_VLD: begin
                if (set_valid) begin
                    cand_d  = set_candidate;
                    state_d = CHECK;
                end
            end
            CHECK: begin
                if (cand_q != exp_q) begin
                    if (errCnt_q != ERR_SAT) begin
                        errNext = errCnt_q + 8'd1;
                    end
                    if (errCnt_q == 8'd0) begin
                        failIdx_d = idx_q;
                    end
                end
                errCnt_d = errNext;
                if (errNext >= MAX_ERR_B) begin
                    pass_d  = 1'b0;
                    state_d = DONE;
                end else if (idx_q == LAST_IDX) begin
                    pass_d  = (errNext == 8'd0);
                    state_d = DONE;
                end else begin
                    idx_d   = idx_q + IDX_ONE;
                    state_d = FETCH;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

`ifdef SET_DRV_WDOG_EN
        if (wdogCount && wdogExpire) begin
            errCnt_d = ERR_SAT;
            pass_d   = 1'b0;
            if (errCnt_q == 8'd0) begin
                failIdx_d = idx_q;
            end
            state_d = DONE;
        end
`endif
    end

    // State and datapath registers; reset puts every output back to zero at once.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            idx_q        <= '0;
            setCentral_q <= '0;
            setRadius_q  <= '0;
            setMode_q    <= MODE_CAND;
            exp_q        <= '0;
            cand_q       <= '0;
            errCnt_q     <= '0;
            failIdx_q    <= '0;
            pass_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            setCentral_q <= setCentral_d;
            setRadius_q  <= setRadius_d;
            setMode_q    <= setMode_d;
            exp_q        <= exp_d;
            cand_q       <= cand_d;
            errCnt_q     <= errCnt_d;
            failIdx_q    <= failIdx_d;
            pass_q       <= pass_d;
        end
    end

    assign rom_addr    = idx_q;
    assign set_en      = (state_q == ISSUE);
    assign set_central = setCentral_q;
    assign set_radius  = setRadius_q;
    assign set_mode    = setMode_q;
    assign running     = (state_q != IDLE) && (state_q != DONE);
    assign done        = (state_q == DONE);
    assign pass        = pass_q;
    assign err_cnt     = errCnt_q;
    assign fail_idx    = failIdx_q;

endmodule

// File: tb/tb_set_pattern_driver.sv
// Self-checking bench for set_pattern_driver.
// Provides a synchronous pattern ROM, a behavioural SET engine with a fixed
// 5-cycle latency and an optional busy stall, and a run-level outcome model.
module tb_set_pattern_driver;
    import set_drv_pkg::*;

    localparam int NPAT  = 64;
    localparam int LAT   = 5;
    localparam int STALL = 20;

    logic        clk;
    logic        rst;
    logic        start;
    logic [1:0]  modeSel;
    logic [5:0]  romAddr;
    logic [23:0] romCentralQ;
    logic [11:0] romRadiusQ;
    logic [7:0]  romExpectedQ;
    logic        setEn;
    logic [23:0] setCentral;
    logic [11:0] setRadius;
    logic [1:0]  setMode;
    logic        setBusy;
    logic        setValid;
    logic [7:0]  setCand;
    logic        running;
    logic        done;
    logic        pass;
    logic [7:0]  errCnt;
    logic [5:0]  failIdx;

    logic [23:0] romCentral [NPAT];
    logic [11:0] romRadius  [NPAT];
    logic [7:0]  romExp     [NPAT];

    int checks = 0;
    int errors = 0;

    int       jobIdx = 0;
    int       enCount = 0;
    logic [1:0] expMode = 2'b00;
    logic     prevEn = 1'b0;
    logic     prevBusy = 1'b0;
    int       latLeft = 0;
    int       stallLeft = 0;
    int       stallIdx = -1;
    int       cycleNo = 0;
    int       fallCycle = -10;
    int       enCycleStall = -100;
    logic [7:0] pendCand = 8'h00;

    set_pattern_driver dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .mode_sel     (modeSel),
        .rom_addr     (romAddr),
        .rom_central  (romCentralQ),
        .rom_radius   (romRadiusQ),
        .rom_expected (romExpectedQ),
        .set_en       (setEn),
        .set_central  (setCentral),
        .set_radius   (setRadius),
        .set_mode     (setMode),
        .set_busy     (setBusy),
        .set_valid    (setValid),
        .set_candidate(setCand),
        .running      (running),
        .done         (done),
        .pass         (pass),
        .err_cnt      (errCnt),
        .fail_idx     (failIdx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous ROM: data for an address appears one clock after it is presented.
    always @(posedge clk) begin
        romCentralQ  <= romCentral[romAddr];
        romRadiusQ   <= romRadius[romAddr];
        romExpectedQ <= romExp[romAddr];
    end

    // The candidate the behavioural SET engine returns for a job.
    function automatic logic [7:0] setFunc(input logic [23:0] c, input logic [11:0] r,
                                           input logic [1:0] m);
        return (c[7:0] ^ c[23:16] ^ r[11:4]) + {6'b000000, m};
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Fill the ROM; bits set in corrupt get a wrong expected candidate.
    task automatic fillRom(input logic [1:0] mode, input logic [63:0] corrupt);
        for (int i = 0; i < NPAT; i++) begin
            romCentral[i] = {8'(i * 5 + 3), 8'(i + 8'h11), 8'(i * 3)};
            romRadius[i]  = 12'(12'h0A0 + i * 7);
            romExp[i]     = setFunc(romCentral[i], romRadius[i], mode) ^ (corrupt[i] ? 8'h5A : 8'h00);
        end
    endtask

    // Run-level outcome straight from the rules: walk patterns, count misses, stop at 10.
    task automatic modelRun(input logic [1:0] mode, output logic expPass, output int expErr,
                            output int expFail, output int expJobs);
        expPass = 1'b0;
        expErr  = 0;
        expFail = 0;
        expJobs = 0;
        for (int i = 0; i < NPAT; i++) begin
            expJobs++;
            if (setFunc(romCentral[i], romRadius[i], mode) != romExp[i]) begin
                if (expErr == 0) expFail = i;
                if (expErr < 255) expErr++;
            end
            if (expErr >= 10) break;
            if (i == NPAT - 1) expPass = (expErr == 0);
        end
    endtask

    task automatic applyStimulus(input logic [1:0] mode);
        @(posedge clk); #1;
        start   = 1'b1;
        modeSel = mode;
        @(posedge clk); #1;
        start   = 1'b0;
    endtask

    task automatic waitDone(input string name);
        int c;
        for (c = 0; c < 4000; c++) begin
            if (done) break;
            @(posedge clk); #1;
        end
        if (!done) checkOutput({name, "_done_timeout"}, 32'(done), 32'd1);
    endtask

    task automatic waitEn(input int n);
        int c;
        for (c = 0; c < 2000; c++) begin
            if (enCount >= n) break;
            @(posedge clk); #1;
        end
        if (enCount < n) checkOutput("en_wait_timeout", 32'(enCount), 32'(n));
    endtask

    task automatic checkRun(input string name, input logic [1:0] mode);
        logic ePass;
        int   eErr, eFail, eJobs;
        modelRun(mode, ePass, eErr, eFail, eJobs);
        checkOutput({name, "_done"}, 32'(done), 32'd1);
        checkOutput({name, "_running"}, 32'(running), 32'd0);
        checkOutput({name, "_pass"}, 32'(pass), 32'(ePass));
        checkOutput({name, "_err_cnt"}, 32'(errCnt), 32'(eErr));
        checkOutput({name, "_fail_idx"}, 32'(failIdx), 32'(eFail));
        checkOutput({name, "_en_pulses"}, 32'(enCount), 32'(eJobs));
    endtask

    // Per-cycle monitor followed by the behavioural SET engine, sampled on the falling edge.
    initial begin
        setBusy  = 1'b0;
        setValid = 1'b0;
        setCand  = 8'h00;
        forever begin
            @(negedge clk);
            cycleNo++;
            if (!rst) begin
                setBusy   = 1'b0;
                setValid  = 1'b0;
                latLeft   = 0;
                stallLeft = 0;
                prevEn    = 1'b0;
                prevBusy  = 1'b0;
                checkOutput("reset_set_en", 32'(setEn), 32'd0);
            end else begin
                if (start && !running) begin
                    expMode = modeSel;
                    jobIdx  = 0;
                    enCount = 0;
                end
                checkOutput("running_done_excl", 32'(running && done), 32'd0);
                if (running) checkOutput("set_mode_stable", 32'(setMode), 32'(expMode));
                if (setEn) begin
                    checkOutput("en_single_cycle", 32'(prevEn), 32'd0);
                    checkOutput("en_while_busy", 32'(prevBusy), 32'd0);
                    if (jobIdx < NPAT) begin
                        checkOutput("job_central", 32'(setCentral), 32'(romCentral[jobIdx]));
                        checkOutput("job_radius", 32'(setRadius), 32'(romRadius[jobIdx]));
                    end
                    if (jobIdx == stallIdx) enCycleStall = cycleNo;
                    jobIdx++;
                    enCount++;
                end
                prevEn = setEn;

                setValid = 1'b0;
                if (setEn) begin
                    setBusy  = 1'b1;
                    latLeft  = LAT;
                    pendCand = setFunc(setCentral, setRadius, setMode);
                end else if (latLeft > 0) begin
                    latLeft--;
                    if (latLeft == 0) begin
                        setValid = 1'b1;
                        setCand  = pendCand;
                        if (jobIdx == stallIdx) stallLeft = STALL;
                        else setBusy = 1'b0;
                    end
                end else if (stallLeft > 0) begin
                    stallLeft--;
                    if (stallLeft <= STALL - 4)
                        checkOutput("stall_central_held", 32'(setCentral), 32'(romCentral[stallIdx]));
                    if (stallLeft == 0) begin
                        setBusy   = 1'b0;
                        fallCycle = cycleNo;
                    end
                end
                prevBusy = setBusy;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL global_timeout: simulation still running at %0t", $time);
        $fatal(1, "[TB] global timeout");
    end

    initial begin
        rst     = 1'b0;
        start   = 1'b0;
        modeSel = 2'b00;
        fillRom(MODE_CAND, 64'd0);
        repeat (3) @(posedge clk);
        #1;

        $display("[TB] reset state");
        checkOutput("rst_rom_addr", 32'(romAddr), 32'd0);
        checkOutput("rst_set_en", 32'(setEn), 32'd0);
        checkOutput("rst_running", 32'(running), 32'd0);
        checkOutput("rst_done", 32'(done), 32'd0);
        checkOutput("rst_pass", 32'(pass), 32'd0);
        checkOutput("rst_err_cnt", 32'(errCnt), 32'd0);
        checkOutput("rst_fail_idx", 32'(failIdx), 32'd0);
        checkOutput("rst_set_mode", 32'(setMode), 32'd0);
        checkOutput("rst_set_central", 32'(setCentral), 32'd0);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        $display("[TB] all patterns match, union mode, stray start mid-run");
        fillRom(MODE_UNION, 64'd0);
        applyStimulus(MODE_UNION);
        checkOutput("t1_running", 32'(running), 32'd1);
        waitEn(4);
        applyStimulus(MODE_ISECT);
        waitDone("t1");
        checkRun("t1", MODE_UNION);
        checkOutput("t1_lit_pass", 32'(pass), 32'd1);
        checkOutput("t1_lit_err", 32'(errCnt), 32'd0);
        checkOutput("t1_lit_en", 32'(enCount), 32'd64);
        checkOutput("t1_lit_mode", 32'(setMode), 32'(MODE_UNION));

        $display("[TB] patterns 3 and 17 wrong");
        fillRom(MODE_DIFF, (64'd1 << 3) | (64'd1 << 17));
        applyStimulus(MODE_DIFF);
        checkOutput("t2_done_cleared", 32'(done), 32'd0);
        waitDone("t2");
        checkRun("t2", MODE_DIFF);
        checkOutput("t2_lit_pass", 32'(pass), 32'd0);
        checkOutput("t2_lit_err", 32'(errCnt), 32'd2);
        checkOutput("t2_lit_fail", 32'(failIdx), 32'd3);

        $display("[TB] patterns 0..11 wrong, early abort");
        fillRom(MODE_CAND, 64'hFFF);
        applyStimulus(MODE_CAND);
        waitDone("t3");
        checkRun("t3", MODE_CAND);
        repeat (30) @(posedge clk);
        #1;
        checkOutput("t3_lit_err", 32'(errCnt), 32'd10);
        checkOutput("t3_lit_fail", 32'(failIdx), 32'd0);
        checkOutput("t3_lit_en", 32'(enCount), 32'd10);
        checkOutput("t3_lit_pass", 32'(pass), 32'd0);
        checkOutput("t3_hold_done", 32'(done), 32'd1);

        $display("[TB] busy held for 20 cycles before pattern 5");
        stallIdx = 5;
        fillRom(MODE_ISECT, 64'd0);
        applyStimulus(MODE_ISECT);
        waitDone("t4");
        checkRun("t4", MODE_ISECT);
        checkOutput("t4_en_after_fall", 32'(enCycleStall), 32'(fallCycle + 1));
        stallIdx = -1;

        $display("[TB] reset during pattern 8 result wait");
        fillRom(MODE_DIFF, 64'h4);
        applyStimulus(MODE_DIFF);
        waitEn(9);
        @(posedge clk);
        #1;
        checkOutput("t5_err_before_reset", 32'(errCnt), 32'd1);
        checkOutput("t5_running_before", 32'(running), 32'd1);
        @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        checkOutput("t5_rst_set_en", 32'(setEn), 32'd0);
        checkOutput("t5_rst_running", 32'(running), 32'd0);
        checkOutput("t5_rst_done", 32'(done), 32'd0);
        checkOutput("t5_rst_err_cnt", 32'(errCnt), 32'd0);
        checkOutput("t5_rst_fail_idx", 32'(failIdx), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        fillRom(MODE_DIFF, 64'd0);
        applyStimulus(MODE_DIFF);
        checkOutput("t5_rerun_addr", 32'(romAddr), 32'd0);
        waitDone("t5");
        checkRun("t5", MODE_DIFF);
        checkOutput("t5_lit_pass", 32'(pass), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
